// File: rtl/id_stage_pipe.sv
// RISC-V decode stage: register file with write-back bypass, immediate generation,
// load-use hazard detection and a registered ID/EX slot with valid/ready on both sides.
module id_stage_pipe #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned NWB  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_inst,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [NWB-1:0]        wb_en,
  input  logic [5*NWB-1:0]      wb_rd,
  input  logic [XLEN*NWB-1:0]   wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_pc,
  output logic [6:0]            out_opcode,
  output logic [2:0]            out_func3,
  output logic [6:0]            out_func7,
  output logic [4:0]            out_rd,
  output logic [4:0]            out_rs1,
  output logic [4:0]            out_rs2,
  output logic [XLEN-1:0]       out_data1,
  output logic [XLEN-1:0]       out_data2,
  output logic [XLEN-1:0]       out_imm,
  output logic                  out_illegal
);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic       RV64      = 1'(XLEN == 64);

  logic [XLEN-1:0] rf_q [32];

  logic [6:0]        opcode_c;
  logic [2:0]        func3_c;
  logic [6:0]        func7_c;
  logic [4:0]        rd_c;
  logic [4:0]        rs1_c;
  logic [4:0]        rs2_c;
  logic [XLEN-1:0]   op1_c;
  logic [XLEN-1:0]   op2_c;
  logic signed [31:0] imm32_c;
  logic [XLEN-1:0]   imm_c;
  logic              illegal_c;
  logic              uses_rs1_c;
  logic              uses_rs2_c;
  logic              hazard_c;
  logic              accept_c;

  logic              valid_q,   valid_d;
  logic [XLEN-1:0]   pc_q,      pc_d;
  logic [6:0]        opcode_q,  opcode_d;
  logic [2:0]        func3_q,   func3_d;
  logic [6:0]        func7_q,   func7_d;
  logic [4:0]        rd_q,      rd_d;
  logic [4:0]        rs1_q,     rs1_d;
  logic [4:0]        rs2_q,     rs2_d;
  logic [XLEN-1:0]   data1_q,   data1_d;
  logic [XLEN-1:0]   data2_q,   data2_d;
  logic [XLEN-1:0]   imm_q,     imm_d;
  logic              illegal_q, illegal_d;

  assign opcode_c = in_inst[6:0];
  assign rd_c     = in_inst[11:7];
  assign func3_c  = in_inst[14:12];
  assign rs1_c    = in_inst[19:15];
  assign rs2_c    = in_inst[24:20];
  assign func7_c  = in_inst[31:25];

  // Register file; later ports overwrite earlier ones on the same rd.
  always_ff @(posedge clk) begin : rf_write
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        rf_q[r] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NWB); i++) begin
        if (wb_en[i] && (wb_rd[5*i +: 5] != 5'd0)) begin
          rf_q[wb_rd[5*i +: 5]] <= wb_data[XLEN*i +: XLEN];
        end
      end
    end
  end

  // Operand read with same-cycle bypass; the highest write-back port wins.
  always_comb begin : operand_read
    op1_c = rf_q[rs1_c];
    op2_c = rf_q[rs2_c];
    for (int i = 0; i < int'(NWB); i++) begin
      if (wb_en[i] && (wb_rd[5*i +: 5] == rs1_c)) begin
        op1_c = wb_data[XLEN*i +: XLEN];
      end
      if (wb_en[i] && (wb_rd[5*i +: 5] == rs2_c)) begin
        op2_c = wb_data[XLEN*i +: XLEN];
      end
    end
    if (rs1_c == 5'd0) begin
      op1_c = '0;
    end
    if (rs2_c == 5'd0) begin
      op2_c = '0;
    end
  end

  // Every format keeps inst[31] at bit 31, so one sign extension to XLEN covers all.
  always_comb begin : imm_decode
    imm32_c   = '0;
    illegal_c = 1'b0;
    case (opcode_c)
      OP_IMM, OP_LOAD, OP_JALR: begin
        imm32_c = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      OP_IMM32: begin
        if (RV64) begin
          imm32_c = {{20{in_inst[31]}}, in_inst[31:20]};
        end else begin
          illegal_c = 1'b1;
        end
      end
      OP_STORE: begin
        imm32_c = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      OP_BRANCH: begin
        imm32_c = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                   in_inst[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        imm32_c = {in_inst[31:12], 12'b0};
      end
      OP_JAL: begin
        imm32_c = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                   in_inst[30:21], 1'b0};
      end
      OP_REG: begin
        imm32_c = '0;
      end
      OP_REG32: begin
        if (!RV64) begin
          illegal_c = 1'b1;
        end
      end
      default: begin
        illegal_c = 1'b1;
      end
    endcase
    imm_c = XLEN'(imm32_c);
  end

  always_comb begin : reg_usage
    uses_rs1_c = !((opcode_c == OP_LUI) || (opcode_c == OP_AUIPC) || (opcode_c == OP_JAL));
    uses_rs2_c = (opcode_c == OP_REG) || (opcode_c == OP_REG32) ||
                 (opcode_c == OP_STORE) || (opcode_c == OP_BRANCH);
  end

  // Load-use against the instruction currently parked in the slot.
  always_comb begin : hazard_detect
    hazard_c = in_valid && valid_q && (opcode_q == OP_LOAD) && (rd_q != 5'd0) &&
               ((uses_rs1_c && (rs1_c == rd_q)) || (uses_rs2_c && (rs2_c == rd_q)));
  end

  assign in_ready = !rst && !flush && !hazard_c && (!valid_q || out_ready);
  assign accept_c = in_valid && in_ready;

  always_comb begin : slot_next
    valid_d   = valid_q && !out_ready && !flush;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    func3_d   = func3_q;
    func7_d   = func7_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    data1_d   = data1_q;
    data2_d   = data2_q;
    imm_d     = imm_q;
    illegal_d = illegal_q;
    if (accept_c) begin
      valid_d   = 1'b1;
      pc_d      = in_pc;
      opcode_d  = opcode_c;
      func3_d   = func3_c;
      func7_d   = func7_c;
      rd_d      = rd_c;
      rs1_d     = rs1_c;
      rs2_d     = rs2_c;
      data1_d   = op1_c;
      data2_d   = op2_c;
      imm_d     = imm_c;
      illegal_d = illegal_c;
    end
  end

  always_ff @(posedge clk) begin : slot_reg
    if (rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      opcode_q  <= '0;
      func3_q   <= '0;
      func7_q   <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      data1_q   <= '0;
      data2_q   <= '0;
      imm_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      func3_q   <= func3_d;
      func7_q   <= func7_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      data1_q   <= data1_d;
      data2_q   <= data2_d;
      imm_q     <= imm_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = pc_q;
  assign out_opcode  = opcode_q;
  assign out_func3   = func3_q;
  assign out_func7   = func7_q;
  assign out_rd      = rd_q;
  assign out_rs1     = rs1_q;
  assign out_rs2     = rs2_q;
  assign out_data1   = data1_q;
  assign out_data2   = data2_q;
  assign out_imm     = imm_q;
  assign out_illegal = illegal_q;

endmodule
